ddr_user_port_arbiter: RTL and testbench



---
 rtl/ddr_arb_pkg.sv | 38 +++
 rtl/rr_priority_picker.sv | 43 ++++
 rtl/ddr_user_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_ddr_user_port_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_arb_pkg.sv
// rtl/ddr_arb_pkg.sv - shared types and helpers for the DDR user-port arbiter
//
// Purpose: FSM state encoding, default widths and the round-robin pick
//          function used by rr_priority_picker.
// Contents: ADDR_W_DEF, DATA_W_DEF, MAX_PORTS, state_t, rr_pick().
package ddr_arb_pkg;

  localparam int ADDR_W_DEF = 26;
  localparam int DATA_W_DEF = 32;
  localparam int MAX_PORTS  = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // First set bit of req at or after ptr, wrapping modulo n (n <= MAX_PORTS).
  // Returns 0 when req is empty; callers qualify with |req.
  function automatic logic [1:0] rr_pick(input logic [MAX_PORTS-1:0] req,
                                         input logic [1:0] ptr,
                                         input int n);
    logic [1:0] win;
    logic       found;
    int         idx;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_PORTS; k++) begin
      idx = (int'(ptr) + k) % n;
      if (k < n && !found && req[idx[1:0]]) begin
        win   = idx[1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin winner selection
//
// Purpose: turns a request vector and a round-robin pointer into a one-hot
//          grant and a winner index.
// Build option: DDR_ARB_FIXED_PRIORITY_EN gives port 0 absolute priority,
//          remaining ports round-robin among themselves.
// Ports:
//   req   in  NUM_PORTS  request levels
//   ptr   in  2          round-robin start position
//   grant out NUM_PORTS  one-hot winner (zero when req is empty)
//   idx   out 2          winner index
//   any   out 1          at least one request present
module rr_priority_picker #(
  parameter int NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [1:0]           ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [1:0]           idx,
  output logic                 any
);
  import ddr_arb_pkg::*;

  logic [MAX_PORTS-1:0] req4;

  always_comb begin
    req4                = '0;
    req4[NUM_PORTS-1:0] = req;
    any                 = |req;
`ifdef DDR_ARB_FIXED_PRIORITY_EN
    // Port 0 masked out of the rotation so the pointer only cycles the others.
    if (req[0]) idx = 2'd0;
    else        idx = rr_pick(req4 & 4'b1110, ptr, NUM_PORTS);
`else
    idx = rr_pick(req4, ptr, NUM_PORTS);
`endif
    grant = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      grant[i] = any && (idx == 2'(i));
    end
  end

endmodule

// File: rtl/ddr_user_port_arbiter.sv
// rtl/ddr_user_port_arbiter.sv - round-robin sharing of the DDR controller user port
//
// Purpose: arbitrates NUM_PORTS requesters onto the single controller user
//          port, one transaction in flight, and routes ACK/read data back
//          to the winner only.
// Build option: DDR_ARB_FIXED_PRIORITY_EN (port 0 absolute priority).
// Ports:
//   CLK, RST (sync, active-high)
//   REQ/WE/WE_ARRAY/ADDRESS/DATAIN  per-port requests, packed by port index
//   ACK/DATAOUT                     completion pulse and read data to clients
//   MEM_REQ/MEM_WE/MEM_WE_ARRAY/MEM_ADDRESS/MEM_DATAIN  registered controller request
//   MEM_ACK/MEM_DATAOUT             controller completion and read data
//   GRANT                           one-hot current owner, zero when idle
module ddr_user_port_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = ddr_arb_pkg::ADDR_W_DEF,
  parameter int DATA_W    = ddr_arb_pkg::DATA_W_DEF
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_PORTS-1:0]        REQ,
  input  logic [NUM_PORTS-1:0]        WE,
  input  logic [4*NUM_PORTS-1:0]      WE_ARRAY,
  input  logic [ADDR_W*NUM_PORTS-1:0] ADDRESS,
  input  logic [DATA_W*NUM_PORTS-1:0] DATAIN,
  output logic [NUM_PORTS-1:0]        ACK,
  output logic [DATA_W-1:0]           DATAOUT,
  output logic                        MEM_REQ,
  output logic                        MEM_WE,
  output logic [3:0]                  MEM_WE_ARRAY,
  output logic [ADDR_W-1:0]           MEM_ADDRESS,
  output logic [DATA_W-1:0]           MEM_DATAIN,
  input  logic                        MEM_ACK,
  input  logic [DATA_W-1:0]           MEM_DATAOUT,
  output logic [NUM_PORTS-1:0]        GRANT
);
  import ddr_arb_pkg::*;

  state_t               state, state_n;
  logic [1:0]           rr_ptr, winner, ptr_next;
  logic [NUM_PORTS-1:0] pick_grant;
  logic [1:0]           pick_idx;
  logic                 pick_any;
  logic                 load, done;
  logic                 sel_we;
  logic [3:0]           sel_be;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_data;

  rr_priority_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
    .req   (REQ),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Slice the winning port's fields out of the packed request buses.
  always_comb begin
    sel_we   = 1'b0;
    sel_be   = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pick_idx == 2'(i)) begin
        sel_we   = WE[i];
        sel_be   = WE_ARRAY[4*i +: 4];
        sel_addr = ADDRESS[ADDR_W*i +: ADDR_W];
        sel_data = DATAIN[DATA_W*i +: DATA_W];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_n;
  end

  // MEM_ACK outside BUSY falls through every branch and is dropped.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    done    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          load    = 1'b1;
          state_n = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (MEM_ACK) begin
          done    = 1'b1;
          state_n = ST_RELEASE;
        end
      end
      ST_RELEASE: state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  assign ptr_next = (winner == 2'(NUM_PORTS-1)) ? 2'd0 : winner + 2'd1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      ACK          <= '0;
      DATAOUT      <= '0;
      MEM_REQ      <= 1'b0;
      MEM_WE       <= 1'b0;
      MEM_WE_ARRAY <= '0;
      MEM_ADDRESS  <= '0;
      MEM_DATAIN   <= '0;
      GRANT        <= '0;
      winner       <= '0;
      rr_ptr       <= '0;
    end else begin
      ACK <= '0;
      if (load) begin
        MEM_REQ      <= 1'b1;
        MEM_WE       <= sel_we;
        MEM_WE_ARRAY <= sel_be;
        MEM_ADDRESS  <= sel_addr;
        MEM_DATAIN   <= sel_data;
        GRANT        <= pick_grant;
        winner       <= pick_idx;
      end
      if (done) begin
        MEM_REQ <= 1'b0;
        ACK     <= GRANT;
        DATAOUT <= MEM_DATAOUT;
`ifdef DDR_ARB_FIXED_PRIORITY_EN
        if (winner != 2'd0) rr_ptr <= ptr_next;
`else
        rr_ptr <= ptr_next;
`endif
      end
      if (state == ST_RELEASE) GRANT <= '0;
    end
  end

endmodule

// File: tb/tb_ddr_user_port_arbiter.sv
// tb/tb_ddr_user_port_arbiter.sv - self-checking bench for ddr_user_port_arbiter
module tb_ddr_user_port_arbiter;
  localparam int NP = 2;
  localparam int AW = 26;
  localparam int DW = 32;

  logic              CLK = 1'b0;
  logic              RST;
  logic [NP-1:0]     REQ, WE;
  logic [4*NP-1:0]   WE_ARRAY;
  logic [AW*NP-1:0]  ADDRESS;
  logic [DW*NP-1:0]  DATAIN;
  logic [NP-1:0]     ACK, GRANT;
  logic [DW-1:0]     DATAOUT, MEM_DATAIN, MEM_DATAOUT;
  logic              MEM_REQ, MEM_WE, MEM_ACK;
  logic [3:0]        MEM_WE_ARRAY;
  logic [AW-1:0]     MEM_ADDRESS;

  ddr_user_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .WE_ARRAY(WE_ARRAY),
    .ADDRESS(ADDRESS), .DATAIN(DATAIN), .ACK(ACK), .DATAOUT(DATAOUT),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_WE_ARRAY(MEM_WE_ARRAY),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_DATAIN(MEM_DATAIN), .MEM_ACK(MEM_ACK),
    .MEM_DATAOUT(MEM_DATAOUT), .GRANT(GRANT)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model state: where the next round-robin search starts, the
  // last delivered read data, and the request captured at arbitration.
  int            exp_ptr = 0;
  logic [DW-1:0] exp_dout = '0;
  int            e_w;
  logic          e_we;
  logic [3:0]    e_be;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_pick(input logic [NP-1:0] r);
`ifdef DDR_ARB_FIXED_PRIORITY_EN
    if (r[0]) return 0;
    for (int k = 0; k < NP; k++) begin
      int i = (exp_ptr + k) % NP;
      if (i != 0 && r[i]) return i;
    end
`else
    for (int k = 0; k < NP; k++) begin
      int i = (exp_ptr + k) % NP;
      if (r[i]) return i;
    end
`endif
    return -1;
  endfunction

  task automatic set_port(input int p, input logic we, input logic [3:0] be,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    WE[p]              = we;
    WE_ARRAY[4*p +: 4] = be;
    ADDRESS[AW*p +: AW] = a;
    DATAIN[DW*p +: DW]  = d;
    REQ[p]             = 1'b1;
  endtask

  task automatic rand_port(input int p);
    set_port(p, 1'($urandom), 4'($urandom), AW'($urandom), $urandom);
  endtask

  // Called in an IDLE cycle with at least one REQ high; arbitration happens
  // at the next edge.
  task automatic start_txn();
    e_w    = exp_pick(REQ);
    e_we   = WE[e_w];
    e_be   = WE_ARRAY[4*e_w +: 4];
    e_addr = ADDRESS[AW*e_w +: AW];
    e_data = DATAIN[DW*e_w +: DW];
    tick();
    check("mem_req_up", MEM_REQ, 1);
    check("grant", GRANT, 64'(1) << e_w);
    check("mem_we", MEM_WE, e_we);
    check("mem_be", MEM_WE_ARRAY, e_be);
    check("mem_addr", MEM_ADDRESS, e_addr);
    check("mem_din", MEM_DATAIN, e_data);
    check("ack_busy", ACK, 0);
  endtask

  task automatic finish_txn(input int lat, input logic [DW-1:0] rdata, input bit new_reqs);
    for (int c = 0; c < lat; c++) begin
      if (new_reqs)
        for (int p = 0; p < NP; p++)
          if (!REQ[p] && $urandom_range(3) == 0) rand_port(p);
      tick();
    end
    check("mem_addr_frozen", MEM_ADDRESS, e_addr);
    check("mem_req_held", MEM_REQ, 1);
    MEM_ACK     = 1'b1;
    MEM_DATAOUT = rdata;
    tick();
    MEM_ACK  = 1'b0;
    exp_dout = rdata;
`ifdef DDR_ARB_FIXED_PRIORITY_EN
    if (e_w != 0) exp_ptr = (e_w + 1) % NP;
`else
    exp_ptr = (e_w + 1) % NP;
`endif
    check("ack_pulse", ACK, 64'(1) << e_w);
    check("dataout", DATAOUT, rdata);
    check("mem_req_down", MEM_REQ, 0);
    REQ[e_w] = 1'b0;
    tick();
    check("ack_clear", ACK, 0);
    check("grant_clear", GRANT, 0);
  endtask

  initial begin
    int order [6];
    RST = 1'b1; REQ = '0; WE = '0; WE_ARRAY = '0; ADDRESS = '0; DATAIN = '0;
    MEM_ACK = 1'b0; MEM_DATAOUT = '0;
    tick(); tick();
    RST = 1'b0;
    check("rst_ack", ACK, 0);
    check("rst_grant", GRANT, 0);
    check("rst_dout", DATAOUT, 0);
    check("rst_mem_req", MEM_REQ, 0);
    check("rst_mem_addr", MEM_ADDRESS, 0);
    check("rst_mem_din", MEM_DATAIN, 0);
    check("rst_mem_be", MEM_WE_ARRAY, 0);

    // Single write from port 0.
    set_port(0, 1'b1, 4'hF, 26'h0000123, 32'hDEADBEEF);
    start_txn();
    finish_txn(4, 32'h11112222, 1'b0);

    // Read from port 1.
    set_port(1, 1'b0, 4'h0, 26'h0000040, 32'h0);
    start_txn();
    finish_txn(2, 32'hCAFEF00D, 1'b0);

    // Both ports hammer continuously.
    for (int t = 0; t < 6; t++) begin
      if (!REQ[0]) rand_port(0);
      if (!REQ[1]) rand_port(1);
      start_txn();
      order[t] = e_w;
      finish_txn(1, $urandom, 1'b0);
    end
    for (int t = 0; t < 6; t++) begin
`ifdef DDR_ARB_FIXED_PRIORITY_EN
      check("order", 64'(order[t]), 0);
`else
      check("order", 64'(order[t]), 64'(t % 2));
`endif
    end
    REQ = '0;

    // Reset in BUSY, then a stray MEM_ACK: no completion.
    set_port(0, 1'b1, 4'h3, 26'h0000777, 32'h01020304);
    start_txn();
    RST = 1'b1;
    tick();
    check("rst_busy_mem_req", MEM_REQ, 0);
    check("rst_busy_grant", GRANT, 0);
    check("rst_busy_dout", DATAOUT, 0);
    check("rst_busy_mem_addr", MEM_ADDRESS, 0);
    RST = 1'b0; REQ = '0; MEM_ACK = 1'b1; MEM_DATAOUT = 32'h55AA55AA;
    tick();
    MEM_ACK = 1'b0;
    check("rst_stray_ack", ACK, 0);
    check("rst_stray_mem_req", MEM_REQ, 0);
    exp_ptr = 0; exp_dout = '0;
    set_port(1, 1'b0, 4'h0, 26'h0000100, 32'h0);
    start_txn();
    finish_txn(3, 32'h0BADF00D, 1'b0);

    // Spurious MEM_ACK while idle.
    MEM_ACK = 1'b1; MEM_DATAOUT = 32'h99999999;
    tick();
    MEM_ACK = 1'b0;
    check("spur_ack", ACK, 0);
    check("spur_dout", DATAOUT, exp_dout);
    check("spur_mem_req", MEM_REQ, 0);
    set_port(0, 1'b1, 4'h1, 26'h0000200, 32'h12345678);
    start_txn();
    finish_txn(0, 32'h87654321, 1'b0);

    // Port 0 drops REQ mid-access; port 1 waits behind it.
    set_port(0, 1'b0, 4'h0, 26'h0000300, 32'h0);
    start_txn();
    REQ[0] = 1'b0;
    set_port(1, 1'b1, 4'hC, 26'h0000400, 32'hA5A5A5A5);
    finish_txn(2, 32'h31415926, 1'b0);
    start_txn();
    finish_txn(1, 32'h27182818, 1'b0);

    // Randomized traffic against the model.
    for (int t = 0; t < 40; t++) begin
      for (int p = 0; p < NP; p++)
        if (!REQ[p] && $urandom_range(1) == 1) rand_port(p);
      if (REQ == '0) rand_port(int'($urandom_range(NP-1)));
      start_txn();
      finish_txn(int'($urandom_range(4)), $urandom, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
